// File: rtl/spi_pkg.sv
// Shared types and constants for the parameterised SPI master.
package spi_pkg;

  localparam int unsigned DATA_W_MAX = 32;

  // Wide enough to count every SCLK edge of the longest supported word.
  localparam int unsigned EDGE_W = $clog2(2 * DATA_W_MAX + 1);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StHold
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  function automatic logic cs_in_range(input int unsigned sel, input int unsigned num);
    return sel < num;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick_o fires every div_i+1 cycles while en_i is high.
module spi_clk_div #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Equality compare against div_i means an all-ones divider never wraps early.
  assign tick_o = en_i && (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parameterised SPI master: transfer FSM, shift registers and chip-select decode.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first bit order; default build is MSB first.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CS = 3,
  parameter int unsigned DIV_W  = 8,
  localparam int unsigned CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ready,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              err,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  spi_state_e        state_q, state_d;
  logic              go_q, go_d;
  spi_mode_t         mode_q, mode_d;
  logic [CS_W-1:0]   sel_q, sel_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              rx_valid_q, rx_valid_d;
  logic              err_q, err_d;

  logic              tick;
  logic              tx_bit;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic              leading;
  logic              last_edge;

  spi_clk_div #(
    .DIV_W(DIV_W)
  ) u_clk_div (
    .clk_i (clk),
    .rst_ni(reset),
    .en_i  (state_q != StIdle),
    .div_i (div_q),
    .tick_o(tick)
  );

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign tx_bit   = tx_sr_q[0];
  assign tx_shift = {1'b0, tx_sr_q[DATA_W-1:1]};
  assign rx_shift = {miso, rx_sr_q[DATA_W-1:1]};
`else
  assign tx_bit   = tx_sr_q[DATA_W-1];
  assign tx_shift = {tx_sr_q[DATA_W-2:0], 1'b0};
  assign rx_shift = {rx_sr_q[DATA_W-2:0], miso};
`endif

  // Even edge index is a leading edge (away from the idle level).
  assign leading   = ~edge_q[0];
  assign last_edge = (edge_q == EDGE_W'(2 * DATA_W - 1));

  always_comb begin
    state_d    = state_q;
    go_d       = go_q;
    mode_d     = mode_q;
    sel_d      = sel_q;
    div_d      = div_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    edge_d     = edge_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // go_q holds the accepted request for one cycle so SETUP begins the cycle after accept.
        if (go_q) begin
          go_d    = 1'b0;
          state_d = StSetup;
          if (!mode_q.cpha) begin
            mosi_d  = tx_bit;
            tx_sr_d = tx_shift;
          end
        end else if (start) begin
          if (cs_in_range(32'(cs_sel), NUM_CS)) begin
            go_d        = 1'b1;
            mode_d.cpol = cpol;
            mode_d.cpha = cpha;
            sel_d       = cs_sel;
            div_d       = clk_div;
            tx_sr_d     = tx_data;
            rx_sr_d     = '0;
            sclk_d      = cpol;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSetup: begin
        if (tick) begin
          state_d = StShift;
          edge_d  = '0;
        end
      end
      StShift: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          // cpha=0 samples on leading edges, cpha=1 on trailing; the other edge shifts out.
          if (leading != mode_q.cpha) begin
            rx_sr_d = rx_shift;
          end else begin
            mosi_d  = tx_bit;
            tx_sr_d = tx_shift;
          end
          if (last_edge) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (tick) begin
          state_d    = StIdle;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      go_q       <= 1'b0;
      mode_q     <= '0;
      sel_q      <= '0;
      div_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      edge_q     <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      go_q       <= go_d;
      mode_q     <= mode_d;
      sel_q      <= sel_d;
      div_q      <= div_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      edge_q     <= edge_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    cs_n = '1;
    if (state_q != StIdle) begin
      for (int unsigned i = 0; i < NUM_CS; i++) begin
        if (32'(sel_q) == i) begin
          cs_n[i] = 1'b0;
        end
      end
    end
  end

  assign ready    = (state_q == StIdle) && !go_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign err      = err_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed self-checking bench for spi_master_param with a mode-aware SPI slave model.
module tb_spi_master_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start;
  logic       ready;
  logic [1:0] cs_sel;
  logic [7:0] tx_data;
  logic       cpol, cpha;
  logic [7:0] clk_div;
  logic [7:0] rx_data;
  logic       rx_valid, err, sclk, mosi;
  logic       miso;
  logic [2:0] cs_n;

  int checks = 0;
  int errors = 0;

  logic loop_en = 1'b0;
  logic cpol_t = 1'b0;
  logic cpha_t = 1'b0;

  always #5 clk = ~clk;

  spi_master_param #(
    .DATA_W(8),
    .NUM_CS(3),
    .DIV_W (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .ready   (ready),
    .cs_sel  (cs_sel),
    .tx_data (tx_data),
    .cpol    (cpol),
    .cpha    (cpha),
    .clk_div (clk_div),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .err     (err),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .cs_n    (cs_n)
  );

  // Slave model: shifts slv_tx out on its launch edge, captures mosi on its sample edge.
  logic [7:0] slv_tx = 8'h00;
  logic [7:0] slv_rx = 8'h00;
  int         slv_idx = 0;
  int         slv_rx_n = 0;
  logic       slv_out = 1'b0;
  logic       slv_first = 1'b0;
  logic       slv_cs_prev = 1'b0;
  logic       slv_sclk_prev = 1'b0;
  wire        cs_any = ~&cs_n;

  assign miso = loop_en ? mosi : slv_out;

  function automatic logic slv_bit(input logic [7:0] w, input int i);
    logic [2:0] k;
    if (i > 7) return 1'b0;
    k = i[2:0];
`ifdef SPI_MASTER_LSB_FIRST_EN
    return w[k];
`else
    return w[3'd7 - k];
`endif
  endfunction

  always @(sclk or cs_any) begin
    if (cs_any && !slv_cs_prev) begin
      slv_rx   <= 8'h00;
      slv_rx_n <= 0;
      if (!cpha_t) begin
        slv_out <= slv_bit(slv_tx, 0);
        slv_idx <= 1;
      end else begin
        slv_idx <= 0;
      end
    end else if (cs_any && (sclk !== slv_sclk_prev)) begin
      if ((sclk !== cpol_t) == cpha_t) begin
        slv_out <= slv_bit(slv_tx, slv_idx);
        slv_idx <= slv_idx + 1;
      end else begin
`ifdef SPI_MASTER_LSB_FIRST_EN
        slv_rx <= {mosi, slv_rx[7:1]};
`else
        slv_rx <= {slv_rx[6:0], mosi};
`endif
        if (slv_rx_n == 0) slv_first <= mosi;
        slv_rx_n <= slv_rx_n + 1;
      end
    end
    slv_cs_prev   = cs_any;
    slv_sclk_prev = sclk;
  end

  // Line monitor: SCLK edges while selected, mosi moving on a sample edge, multiple selects.
  int         edge_cnt = 0;
  int         phase_bad = 0;
  int         onehot_bad = 0;
  logic [2:0] cs_seen = 3'b111;
  logic       mon_sclk = 1'b0;
  logic       mon_mosi = 1'b0;

  always @(posedge clk) begin
    #1;
    if (cs_any) begin
      cs_seen = cs_n;
      if (sclk !== mon_sclk) begin
        edge_cnt++;
        if ((mosi !== mon_mosi) && ((sclk !== cpol_t) != cpha_t)) phase_bad++;
      end
    end
    if ($countones(~cs_n) > 1) onehot_bad++;
    mon_sclk = sclk;
    mon_mosi = mosi;
  end

  task automatic xfer(input logic [1:0] sel, input logic [7:0] data, input logic pol,
                      input logic pha, input logic [7:0] div, input logic lp,
                      output logic [7:0] got, output int lat, output int edges);
    int e0;
    int budget;
    @(negedge clk);
    cs_sel  = sel;
    tx_data = data;
    cpol    = pol;
    cpha    = pha;
    clk_div = div;
    loop_en = lp;
    cpol_t  = pol;
    cpha_t  = pha;
    start   = 1'b1;
    e0      = edge_cnt;
    @(negedge clk);
    start  = 1'b0;
    lat    = 0;
    budget = 1 + 18 * (int'(div) + 1) + 20;
    while (rx_valid !== 1'b1 && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    got   = rx_data;
    edges = edge_cnt - e0;
  endtask

  task automatic test_reset();
    start   = 1'b0;
    cs_sel  = 2'd0;
    tx_data = 8'h00;
    cpol    = 1'b0;
    cpha    = 1'b0;
    clk_div = 8'd0;
    reset   = 1'b0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    if (cs_n !== 3'b111) begin errors++; $display("FAIL reset_cs_n: got %b want 111", cs_n); end
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    // Invalid select right at deassertion: err proves start is sampled on the first edge.
    reset  = 1'b1;
    cs_sel = 2'd3;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL reset_first_edge_err: got %b want 1", err); end
  endtask

  task automatic test_mode0_loopback();
    logic [7:0] got;
    int lat, edges, pb;
    pb = phase_bad;
    xfer(2'd1, 8'hA5, 1'b0, 1'b0, 8'd1, 1'b1, got, lat, edges);
    checks += 6;
    if (got !== 8'hA5) begin errors++; $display("FAIL mode0_rx: got %h want a5", got); end
    if (lat != 37) begin errors++; $display("FAIL mode0_latency: got %0d want 37", lat); end
    if (edges != 16) begin errors++; $display("FAIL mode0_edges: got %0d want 16", edges); end
    if (cs_seen !== 3'b101) begin errors++; $display("FAIL mode0_cs_sel: got %b want 101", cs_seen); end
    if (cs_n !== 3'b111 || ready !== 1'b1) begin
      errors++; $display("FAIL mode0_done: got cs_n=%b ready=%b want 111/1", cs_n, ready);
    end
    if (phase_bad != pb) begin errors++; $display("FAIL mode0_phase: got %0d want %0d", phase_bad, pb); end
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL mode0_valid_pulse: got %b want 0", rx_valid); end
  endtask

  task automatic test_modes();
    logic [7:0] got;
    int lat, edges, exp_lat, pb;
    logic [1:0] sels [3] = '{2'd0, 2'd2, 2'd1};
    logic       pols [3] = '{1'b0, 1'b1, 1'b1};
    logic       phas [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] divs [3] = '{8'd0, 8'd2, 8'd0};
    for (int m = 0; m < 3; m++) begin
      slv_tx  = 8'hC3;
      pb      = phase_bad;
      exp_lat = 1 + 18 * (int'(divs[m]) + 1);
      xfer(sels[m], 8'h3C, pols[m], phas[m], divs[m], 1'b0, got, lat, edges);
      checks += 6;
      if (got !== 8'hC3) begin errors++; $display("FAIL mode%0d_rx: got %h want c3", m + 1, got); end
      if (slv_rx !== 8'h3C) begin
        errors++; $display("FAIL mode%0d_slave_rx: got %h want 3c", m + 1, slv_rx);
      end
      if (edges != 16) begin errors++; $display("FAIL mode%0d_edges: got %0d want 16", m + 1, edges); end
      if (lat != exp_lat) begin
        errors++; $display("FAIL mode%0d_latency: got %0d want %0d", m + 1, lat, exp_lat);
      end
      if (sclk !== pols[m]) begin
        errors++; $display("FAIL mode%0d_idle_sclk: got %b want %b", m + 1, sclk, pols[m]);
      end
      if (phase_bad != pb) begin
        errors++; $display("FAIL mode%0d_phase: got %0d want %0d", m + 1, phase_bad, pb);
      end
    end
  endtask

  task automatic test_bad_cs();
    int e0, err_n, cs_bad, rdy_bad;
    logic s0;
    @(negedge clk);
    e0     = edge_cnt;
    s0     = sclk;
    cs_sel = 2'd3;
    cpol   = ~sclk;
    start  = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    err_n   = (err === 1'b1) ? 1 : 0;
    cs_bad  = 0;
    rdy_bad = 0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL badcs_err_next: got %b want 1", err); end
    repeat (12) begin
      @(negedge clk);
      if (err === 1'b1) err_n++;
      if (cs_n !== 3'b111) cs_bad++;
      if (ready !== 1'b1) rdy_bad++;
    end
    checks += 5;
    if (err_n != 1) begin errors++; $display("FAIL badcs_err_count: got %0d want 1", err_n); end
    if (cs_bad != 0) begin errors++; $display("FAIL badcs_cs_n: got %0d bad cycles want 0", cs_bad); end
    if (rdy_bad != 0) begin errors++; $display("FAIL badcs_ready: got %0d bad cycles want 0", rdy_bad); end
    if (sclk !== s0) begin errors++; $display("FAIL badcs_sclk: got %b want %b", sclk, s0); end
    if (edge_cnt != e0) begin errors++; $display("FAIL badcs_edges: got %0d want %0d", edge_cnt, e0); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] got;
    int lat, edges;
    @(negedge clk);
    cs_sel  = 2'd2;
    tx_data = 8'h5A;
    cpol    = 1'b0;
    cpha    = 1'b0;
    clk_div = 8'd1;
    loop_en = 1'b1;
    cpol_t  = 1'b0;
    cpha_t  = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks += 4;
    if (cs_n !== 3'b111) begin errors++; $display("FAIL abort_cs_n: got %b want 111", cs_n); end
    if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", ready); end
    if (sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk: got %b want 0", sclk); end
    if (rx_data !== 8'h00) begin errors++; $display("FAIL abort_rx_data: got %h want 00", rx_data); end
    @(negedge clk);
    reset = 1'b1;
    xfer(2'd0, 8'h69, 1'b0, 1'b0, 8'd1, 1'b1, got, lat, edges);
    checks += 2;
    if (got !== 8'h69) begin errors++; $display("FAIL abort_next_rx: got %h want 69", got); end
    if (lat != 37) begin errors++; $display("FAIL abort_next_latency: got %0d want 37", lat); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got1, got2;
    int lat1, gap, extra;
    @(negedge clk);
    cs_sel  = 2'd0;
    tx_data = 8'h5A;
    cpol    = 1'b0;
    cpha    = 1'b0;
    clk_div = 8'd0;
    loop_en = 1'b1;
    cpol_t  = 1'b0;
    cpha_t  = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    // Changing tx_data after accept must not affect the word in flight.
    tx_data = 8'h96;
    lat1 = 0;
    while (rx_valid !== 1'b1 && lat1 < 60) begin
      @(negedge clk);
      lat1++;
    end
    got1 = rx_data;
    gap  = 0;
    @(negedge clk);
    gap++;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: got ready=%b want 0", ready); end
    while (rx_valid !== 1'b1 && gap < 60) begin
      @(negedge clk);
      gap++;
    end
    got2  = rx_data;
    start = 1'b0;
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (rx_valid === 1'b1) extra++;
    end
    checks += 5;
    if (got1 !== 8'h5A) begin errors++; $display("FAIL b2b_rx1: got %h want 5a", got1); end
    if (lat1 != 19) begin errors++; $display("FAIL b2b_latency: got %0d want 19", lat1); end
    if (got2 !== 8'h96) begin errors++; $display("FAIL b2b_rx2: got %h want 96", got2); end
    if (gap != 20) begin errors++; $display("FAIL b2b_gap: got %0d want 20", gap); end
    if (extra != 0) begin errors++; $display("FAIL b2b_extra: got %0d want 0", extra); end
  endtask

  task automatic test_bit_order();
    logic [7:0] got;
    int lat, edges;
    logic exp_first;
`ifdef SPI_MASTER_LSB_FIRST_EN
    exp_first = 1'b1;
`else
    exp_first = 1'b0;
`endif
    xfer(2'd1, 8'h01, 1'b0, 1'b0, 8'd0, 1'b1, got, lat, edges);
    checks += 3;
    if (got !== 8'h01) begin errors++; $display("FAIL order_rx: got %h want 01", got); end
    if (slv_first !== exp_first) begin
      errors++; $display("FAIL order_first_bit: got %b want %b", slv_first, exp_first);
    end
    if (slv_rx !== 8'h01) begin errors++; $display("FAIL order_mosi_word: got %h want 01", slv_rx); end
  endtask

  task automatic test_div_max();
    logic [7:0] got;
    int lat, edges;
    xfer(2'd2, 8'hE7, 1'b0, 1'b1, 8'hFF, 1'b1, got, lat, edges);
    checks += 3;
    if (got !== 8'hE7) begin errors++; $display("FAIL divmax_rx: got %h want e7", got); end
    if (lat != 4609) begin errors++; $display("FAIL divmax_latency: got %0d want 4609", lat); end
    if (edges != 16) begin errors++; $display("FAIL divmax_edges: got %0d want 16", edges); end
  endtask

  initial begin
    test_reset();
    test_mode0_loopback();
    test_modes();
    test_bad_cs();
    test_reset_abort();
    test_back_to_back();
    test_bit_order();
    test_div_max();
    checks++;
    if (onehot_bad != 0) begin errors++; $display("FAIL cs_onehot: got %0d bad cycles want 0", onehot_bad); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master_param.md
SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: bits per transfer, range 2..32.
REQ-002 The block SHALL have parameter NUM_CS, default 3: number of chip selects, range 1..8.
REQ-003 The block SHALL have parameter DIV_W, default 8: width of the clock-divider input.
REQ-004 The block SHALL have port clk  input  1: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 The block SHALL have port start  input  1: transfer request, sampled while ready=1.
REQ-007 The block SHALL have port ready  output  1: idle, able to accept start.
REQ-008 The block SHALL have port cs_sel  input  $clog2(NUM_CS) (minimum 1): target slave index.
REQ-009 The block SHALL have port tx_data  input  DATA_W: word to shift out on mosi.
REQ-010 The block SHALL have port cpol  input  1: SCLK idle level.
REQ-011 The block SHALL have port cpha  input  1: sampling phase, 0 = sample on the leading edge.
REQ-012 The block SHALL have port clk_div  input  DIV_W: SCLK half-period is clk_div+1 clk cycles.
REQ-013 The block SHALL have port rx_data  output  DATA_W: last received word.
REQ-014 The block SHALL have port rx_valid  output  1: one-cycle pulse when rx_data updates.
REQ-015 The block SHALL have port err  output  1: one-cycle pulse when a start is rejected.
REQ-016 The block SHALL have ports sclk  output  1, mosi  output  1, miso  input  1: the serial lines.
REQ-017 The block SHALL have port cs_n  output  NUM_CS: active-low chip selects.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, SHIFT and HOLD; ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, start=1 with cs_sel<NUM_CS SHALL latch tx_data, cs_sel, cpol, cpha and clk_div, and SHALL move to SETUP on the next cycle.
REQ-020 In IDLE, start=1 with cs_sel>=NUM_CS SHALL pulse err on the next cycle and SHALL stay in IDLE with no line activity.
REQ-021 start SHALL be ignored outside IDLE, and latched values SHALL NOT change mid-transfer.
REQ-022 Let H = clk_div+1. SETUP SHALL last H cycles, with cs_n[sel]=0 and mosi driven with the first bit when cpha=0.
REQ-023 SHIFT SHALL produce exactly 2*DATA_W SCLK edges, spaced H cycles apart, starting from the latched cpol level.
REQ-024 When cpha=0, miso SHALL be sampled on each leading edge and mosi SHALL update on each trailing edge.
REQ-025 When cpha=1, mosi SHALL update on each leading edge and miso SHALL be sampled on each trailing edge.
REQ-026 HOLD SHALL last H cycles with sclk at the cpol level and cs_n[sel] still 0.
REQ-027 On the cycle after HOLD, the block SHALL drive all cs_n to 1, update rx_data, pulse rx_valid for one cycle and set ready=1.
REQ-028 Latency from the accept cycle T to rx_valid SHALL be T+1+(2*DATA_W+2)*H.
REQ-029 clk_div=0 SHALL give H=1 (sclk = clk/2), and clk_div=all-ones SHALL not overflow the divider counter.
REQ-030 At most one cs_n bit SHALL be low at any time.
REQ-031 In IDLE, sclk SHALL hold the last latched cpol.

Reset
REQ-032 Reset assertion SHALL immediately abort any transfer and return the FSM to IDLE.
REQ-033 During reset, outputs SHALL be: sclk=0, mosi=0, cs_n=all ones, ready=1, rx_valid=0, err=0, rx_data=0.
REQ-034 After reset deassertion, start SHALL be accepted from the first rising clk edge.

Configuration
REQ-035 The macro SPI_MASTER_LSB_FIRST_EN SHALL control bit order.
REQ-036 With SPI_MASTER_LSB_FIRST_EN defined, tx_data[0] SHALL be sent first and the first received bit SHALL land in rx_data[0].
REQ-037 Without SPI_MASTER_LSB_FIRST_EN, the bit order SHALL be MSB first for both directions.

Structure
REQ-038 Package spi_pkg SHALL hold the FSM state enum, the mode typedef {cpol, cpha} and the constant DATA_W_MAX=32.
REQ-039 Sub-module spi_clk_div SHALL generate the half-period tick from the latched clk_div.
REQ-040 The FSM, shift registers and chip-select decode SHALL be in spi_master_param.

Verification
REQ-041 Mode 0, DATA_W=8, clk_div=1, tx_data=0xA5, miso looped to mosi -> rx_data=0xA5, rx_valid at T+37, exactly 16 sclk edges.
REQ-042 Modes 1/2/3 with tx_data=0x3C and a slave model returning 0xC3 -> rx_data=0xC3 each time, sclk idling at cpol, and edge/sample phase per REQ-024 and REQ-025.
REQ-043 cs_sel=3 with NUM_CS=3 -> err pulses once, cs_n stays 3'b111, no sclk toggle, ready stays 1.
REQ-044 Reset pulled low mid-SHIFT, then start again -> cs_n=all ones and ready=1 at once, and the next transfer completes normally.
REQ-045 Start held high across back-to-back transfers -> a second transfer begins the cycle after rx_valid, and starts issued while busy are ignored.
REQ-046 Build with SPI_MASTER_LSB_FIRST_EN, tx_data=0x01 -> mosi is 1 on the first bit only, and the loopback rx_data=0x01.
